ps2_device: RTL and testbench



---
 rtl/ps2_device.sv | 231 +++++++++++++++++++++++
 tb/tb_ps2_device.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_device.sv
// PS/2 device-side endpoint: drives the PS/2 clock, sends bytes to the host and
// receives host command frames after a request-to-send, answering with the ack bit.
module ps2_device #(
    parameter int pClkFreq = 40000000,
    parameter int pHalf    = pClkFreq / 25000,
    parameter int pFilt    = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] tx_data_i,
    input  logic       tx_valid_i,
    output logic       tx_ready_o,
    output logic       tx_abort_o,
    output logic [7:0] rx_data_o,
    output logic       rx_valid_o,
    output logic       rx_perr_o,
    output logic       rx_ferr_o,
    output logic       busy_o,
    input  logic       kclk_i,
    output logic       kclk_en,
    input  logic       kdat_i,
    output logic       kdat_en
);
    localparam int FW = $clog2(pFilt + 1);
    localparam logic [15:0] HALF_END = 16'(pHalf - 1);
    localparam logic [15:0] HALF_MID = 16'(pHalf / 2);
    localparam logic [15:0] HALF_LEN = 16'(pHalf);

    typedef enum logic [2:0] {IDLE, TX_HI, TX_LO, RX_LO, RX_HI} state_t;
    state_t state_q, state_d;

    logic [1:0]    sclk_q, sdat_q;
    logic          fclk_q, fclk_d, fdat_q, fdat_d;
    logic [FW-1:0] fcclk_q, fcclk_d, fcdat_q, fcdat_d;
    logic [15:0]   timer_q, timer_d, idle_q, idle_d;
    logic [3:0]    bitcnt_q, bitcnt_d;
    logic [10:0]   txsh_q, txsh_d;
    logic [9:0]    rxsh_q, rxsh_d;
    logic          ack_q, ack_d;
    logic [7:0]    rx_data_q, rx_data_d;
    logic          perr_q, perr_d, rx_valid_q, rx_valid_d, ferr_q, ferr_d;
    logic          abort_q, abort_d, busy_q, busy_d, tx_ready_q, tx_ready_d;
    logic          kclk_en_q, kclk_en_d, kdat_en_q, kdat_en_d;
    logic          phase_end;

    assign phase_end = (timer_q == HALF_END);

    // State register: every register of the block, lines released on reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            sclk_q     <= 2'b11;
            sdat_q     <= 2'b11;
            fclk_q     <= 1'b1;
            fdat_q     <= 1'b1;
            fcclk_q    <= '0;
            fcdat_q    <= '0;
            timer_q    <= '0;
            idle_q     <= '0;
            bitcnt_q   <= '0;
            txsh_q     <= '0;
            rxsh_q     <= '0;
            ack_q      <= 1'b0;
            rx_data_q  <= '0;
            perr_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            ferr_q     <= 1'b0;
            abort_q    <= 1'b0;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b0;
            kclk_en_q  <= 1'b0;
            kdat_en_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sclk_q     <= {sclk_q[0], kclk_i};
            sdat_q     <= {sdat_q[0], kdat_i};
            fclk_q     <= fclk_d;
            fdat_q     <= fdat_d;
            fcclk_q    <= fcclk_d;
            fcdat_q    <= fcdat_d;
            timer_q    <= timer_d;
            idle_q     <= idle_d;
            bitcnt_q   <= bitcnt_d;
            txsh_q     <= txsh_d;
            rxsh_q     <= rxsh_d;
            ack_q      <= ack_d;
            rx_data_q  <= rx_data_d;
            perr_q     <= perr_d;
            rx_valid_q <= rx_valid_d;
            ferr_q     <= ferr_d;
            abort_q    <= abort_d;
            busy_q     <= busy_d;
            tx_ready_q <= tx_ready_d;
            kclk_en_q  <= kclk_en_d;
            kdat_en_q  <= kdat_en_d;
        end
    end

    // A filtered level flips only after pFilt consecutive samples that disagree with it.
    always_comb begin
        fclk_d  = fclk_q;
        fcclk_d = '0;
        fdat_d  = fdat_q;
        fcdat_d = '0;
        if (sclk_q[1] != fclk_q) begin
            fcclk_d = fcclk_q + 1'b1;
            if (fcclk_q == FW'(pFilt - 1)) begin
                fclk_d  = sclk_q[1];
                fcclk_d = '0;
            end
        end
        if (sdat_q[1] != fdat_q) begin
            fcdat_d = fcdat_q + 1'b1;
            if (fcdat_q == FW'(pFilt - 1)) begin
                fdat_d  = sdat_q[1];
                fcdat_d = '0;
            end
        end
    end

    // Next-state and datapath.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q + 16'd1;
        idle_d     = '0;
        bitcnt_d   = bitcnt_q;
        txsh_d     = txsh_q;
        rxsh_d     = rxsh_q;
        ack_d      = ack_q;
        rx_data_d  = rx_data_q;
        perr_d     = perr_q;
        rx_valid_d = 1'b0;
        ferr_d     = 1'b0;
        abort_d    = 1'b0;
        case (state_q)
            IDLE: begin
                ack_d = 1'b0;
                if (fclk_q && fdat_q)
                    idle_d = (idle_q >= HALF_LEN) ? idle_q : idle_q + 16'd1;
                timer_d = (fclk_q && !fdat_q) ? timer_q + 16'd1 : '0;
                // Host request-to-send wins over a byte offered in the same cycle.
                if (fclk_q && !fdat_q && phase_end) begin
                    state_d  = RX_LO;
                    timer_d  = '0;
                    bitcnt_d = '0;
                end else if (tx_valid_i && tx_ready_q) begin
                    state_d  = TX_HI;
                    timer_d  = '0;
                    txsh_d   = {1'b1, ~^tx_data_i, tx_data_i, 1'b0};
                    bitcnt_d = 4'd11;
                end
            end
            TX_HI: begin
                if (phase_end) begin
                    timer_d = '0;
                    if (!fclk_q && bitcnt_q != 4'd1) begin
                        state_d = IDLE;
                        abort_d = 1'b1;
                    end else begin
                        state_d = TX_LO;
                    end
                end
            end
            TX_LO: begin
                if (phase_end) begin
                    timer_d  = '0;
                    txsh_d   = {1'b0, txsh_q[10:1]};
                    bitcnt_d = bitcnt_q - 4'd1;
                    state_d  = (bitcnt_q == 4'd1) ? IDLE : TX_HI;
                end
            end
            RX_LO: begin
                if (phase_end) begin
                    timer_d = '0;
                    state_d = RX_HI;
                end
            end
            RX_HI: begin
                if (!ack_q && timer_q == HALF_MID)
                    rxsh_d = {fdat_q, rxsh_q[9:1]};
                if (phase_end) begin
                    timer_d = '0;
                    if (!fclk_q) begin
                        state_d = IDLE;
                    end else if (ack_q) begin
                        state_d    = IDLE;
                        rx_data_d  = rxsh_q[7:0];
                        perr_d     = ~^rxsh_q[8:0];
                        rx_valid_d = 1'b1;
                    end else if (bitcnt_q == 4'd9) begin
                        if (rxsh_q[9]) begin
                            ack_d   = 1'b1;
                            state_d = RX_LO;
                        end else begin
                            ferr_d  = 1'b1;
                            state_d = IDLE;
                        end
                    end else begin
                        bitcnt_d = bitcnt_q + 4'd1;
                        state_d  = RX_LO;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so the lines never glitch.
    // tx handshake: a byte transfers on a cycle where tx_valid_i and tx_ready_o are both
    // high; tx_ready_o is only high in IDLE after pHalf cycles of both lines idle.
    always_comb begin
        kclk_en_d  = (state_d == TX_LO) || (state_d == RX_LO);
        kdat_en_d  = 1'b0;
        if (state_d == TX_HI || state_d == TX_LO)
            kdat_en_d = ~txsh_d[0];
        else if (state_d == RX_LO || state_d == RX_HI)
            kdat_en_d = ack_d;
        busy_d     = (state_d != IDLE);
        tx_ready_d = (state_d == IDLE) && (idle_d >= HALF_LEN);
    end

    assign tx_ready_o = tx_ready_q;
    assign tx_abort_o = abort_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign rx_perr_o  = perr_q;
    assign rx_ferr_o  = ferr_q;
    assign busy_o     = busy_q;
    assign kclk_en    = kclk_en_q;
    assign kdat_en    = kdat_en_q;
endmodule

// File: tb/tb_ps2_device.sv
// Directed bench for ps2_device: an open-collector host model drives both lines and
// every expected value below is worked out by hand from the frame format.
module tb_ps2_device;
    localparam int P_HALF = 20;
    localparam int P_FILT = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data_i = 8'h00;
    logic       tx_valid_i = 1'b0;
    logic       tx_ready_o, tx_abort_o, rx_valid_o, rx_perr_o, rx_ferr_o, busy_o;
    logic [7:0] rx_data_o;
    logic       kclk_en, kdat_en;
    logic       host_clk_low = 1'b0;
    logic       host_dat_low = 1'b0;
    logic       kclk_line, kdat_line;

    assign kclk_line = ~(kclk_en | host_clk_low);
    assign kdat_line = ~(kdat_en | host_dat_low);

    ps2_device #(.pHalf(P_HALF), .pFilt(P_FILT)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .tx_data_i  (tx_data_i),
        .tx_valid_i (tx_valid_i),
        .tx_ready_o (tx_ready_o),
        .tx_abort_o (tx_abort_o),
        .rx_data_o  (rx_data_o),
        .rx_valid_o (rx_valid_o),
        .rx_perr_o  (rx_perr_o),
        .rx_ferr_o  (rx_ferr_o),
        .busy_o     (busy_o),
        .kclk_i     (kclk_line),
        .kclk_en    (kclk_en),
        .kdat_i     (kdat_line),
        .kdat_en    (kdat_en)
    );

    // clock / reset
    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // line and pulse monitors
    int n_clk_pulse = 0;
    int n_kdat_cyc = 0;
    int n_busy_cyc = 0;
    int n_ready_cyc = 0;
    int n_rxv = 0;
    int n_ferr = 0;
    int n_abort = 0;
    logic [7:0] last_rx_data = 8'h00;
    logic       last_perr = 1'b0;
    logic       prev_kclk_en = 1'b0;

    always @(negedge clk) begin
        if (kclk_en && !prev_kclk_en) n_clk_pulse++;
        prev_kclk_en = kclk_en;
        if (kdat_en) n_kdat_cyc++;
        if (busy_o) n_busy_cyc++;
        if (tx_ready_o) n_ready_cyc++;
        if (rx_ferr_o) n_ferr++;
        if (tx_abort_o) n_abort++;
        if (rx_valid_o) begin
            n_rxv++;
            last_rx_data = rx_data_o;
            last_perr = rx_perr_o;
        end
    end

    // driver / wait tasks
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_kclk_en(input logic lvl, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (kclk_en == lvl) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_pulses(input int target, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (n_clk_pulse >= target) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_busy_low(input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            step();
            if (!busy_o) begin
                ok = 1'b1;
                return;
            end
        end
    endtask

    task automatic wait_ready(input int budget, output int cycles);
        cycles = 0;
        while (!tx_ready_o && cycles < budget) begin
            step();
            cycles++;
        end
    endtask

    // Host request-to-send followed by 10 host-driven bits (d0..d7, parity, stop).
    task automatic host_send(input logic [7:0] d, input logic par, input logic stp, output bit ok);
        logic [9:0] bits;
        int base;
        bit w_ok;
        bits = {stp, par, d};
        base = n_clk_pulse;
        ok = 1'b1;
        host_clk_low = 1'b1;
        repeat (5 * P_HALF) step();
        host_dat_low = 1'b1;
        repeat (4) step();
        host_clk_low = 1'b0;
        for (int i = 0; i < 10; i++) begin
            wait_pulses(base + i + 1, 4 * P_HALF, w_ok);
            ok &= w_ok;
            host_dat_low = ~bits[i];
        end
        if (stp) begin
            wait_pulses(base + 11, 4 * P_HALF, w_ok);
            ok &= w_ok;
        end
        wait_busy_low(6 * P_HALF, w_ok);
        ok &= w_ok;
        host_dat_low = 1'b0;
        repeat (4) step();
    endtask

    initial begin
        bit ok;
        int cyc, wmin, wmax, w;
        int b0, p0, k0, r0, f0, a0, rd0;
        logic [10:0] seq;
        logic [10:0] exp_seq;

        // reset state
        repeat (3) step();
        check("rst_kclk_en", kclk_en, 1'b0);
        check("rst_kdat_en", kdat_en, 1'b0);
        check("rst_tx_ready", tx_ready_o, 1'b0);
        check("rst_tx_abort", tx_abort_o, 1'b0);
        check("rst_rx_valid", rx_valid_o, 1'b0);
        check("rst_rx_perr", rx_perr_o, 1'b0);
        check("rst_rx_ferr", rx_ferr_o, 1'b0);
        check("rst_rx_data", rx_data_o, 8'h00);
        check("rst_busy", busy_o, 1'b0);
        rst = 1'b0;

        // device-to-host frame 0x1C
        wait_ready(3 * P_HALF, cyc);
        check("tx_ready_before_accept", tx_ready_o, 1'b1);
        b0 = n_busy_cyc;
        tx_data_i = 8'h1C;
        tx_valid_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
        check("tx_busy_after_accept", busy_o, 1'b1);
        seq = '0;
        wmin = 1000;
        wmax = 0;
        ok = 1'b1;
        for (int i = 0; i < 11; i++) begin
            bit w_ok;
            wait_kclk_en(1'b1, 2 * P_HALF, w_ok);
            ok &= w_ok;
            seq[i] = kdat_line;
            w = 0;
            while (kclk_en && w < 4 * P_HALF) begin
                w++;
                step();
            end
            if (w < wmin) wmin = w;
            if (w > wmax) wmax = w;
        end
        check("tx_clk_pulses_seen", ok, 1'b1);
        exp_seq = 11'h438;
        check("tx_kdat_seq", seq, exp_seq);
        check("tx_low_min", wmin, P_HALF);
        check("tx_low_max", wmax, P_HALF);
        wait_busy_low(2 * P_HALF, ok);
        check("tx_frame_end", ok, 1'b1);
        check("tx_frame_len", n_busy_cyc - b0, 22 * P_HALF);
        wait_ready(3 * P_HALF, cyc);
        check("tx_ready_return", (cyc >= P_HALF) && (cyc <= P_HALF + P_FILT + 4), 1'b1);

        // host-to-device 0xED, good parity
        p0 = n_clk_pulse; k0 = n_kdat_cyc; r0 = n_rxv; f0 = n_ferr;
        host_send(8'hED, 1'b1, 1'b1, ok);
        check("rx1_handshake", ok, 1'b1);
        check("rx1_pulses", n_clk_pulse - p0, 11);
        check("rx1_ack_cycles", n_kdat_cyc - k0, 2 * P_HALF);
        check("rx1_valid_cnt", n_rxv - r0, 1);
        check("rx1_data", last_rx_data, 8'hED);
        check("rx1_perr", last_perr, 1'b0);
        check("rx1_ferr_cnt", n_ferr - f0, 0);

        // host-to-device 0xED, bad parity: still acked
        p0 = n_clk_pulse; k0 = n_kdat_cyc; r0 = n_rxv;
        host_send(8'hED, 1'b0, 1'b1, ok);
        check("rx2_handshake", ok, 1'b1);
        check("rx2_ack_cycles", n_kdat_cyc - k0, 2 * P_HALF);
        check("rx2_valid_cnt", n_rxv - r0, 1);
        check("rx2_data", last_rx_data, 8'hED);
        check("rx2_perr", last_perr, 1'b1);

        // framing error 0xF4 with stop 0
        p0 = n_clk_pulse; k0 = n_kdat_cyc; r0 = n_rxv; f0 = n_ferr;
        host_send(8'hF4, 1'b0, 1'b0, ok);
        check("rx3_handshake", ok, 1'b1);
        check("rx3_pulses", n_clk_pulse - p0, 10);
        check("rx3_no_ack", n_kdat_cyc - k0, 0);
        check("rx3_ferr_cnt", n_ferr - f0, 1);
        check("rx3_no_valid", n_rxv - r0, 0);
        check("rx3_data_kept", rx_data_o, 8'hED);

        // transmit 0xAA, host inhibits during the 5th high phase
        wait_ready(4 * P_HALF, cyc);
        check("inh_ready", tx_ready_o, 1'b1);
        a0 = n_abort;
        tx_data_i = 8'hAA;
        tx_valid_i = 1'b1;
        step();
        tx_valid_i = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bit w_ok;
            wait_kclk_en(1'b1, 2 * P_HALF, w_ok);
            ok &= w_ok;
            wait_kclk_en(1'b0, 2 * P_HALF, w_ok);
            ok &= w_ok;
        end
        check("inh_four_bits", ok, 1'b1);
        repeat (P_HALF / 4) step();
        host_clk_low = 1'b1;
        for (int c = 0; c < 2 * P_HALF && n_abort == a0; c++) step();
        check("inh_abort_cnt", n_abort - a0, 1);
        check("inh_kclk_en", kclk_en, 1'b0);
        check("inh_kdat_en", kdat_en, 1'b0);
        check("inh_busy", busy_o, 1'b0);
        repeat (2 * P_HALF) step();
        check("inh_ready_low", tx_ready_o, 1'b0);
        host_clk_low = 1'b0;
        wait_ready(3 * P_HALF, cyc);
        check("inh_ready_return", (cyc >= P_HALF) && (cyc <= P_HALF + P_FILT + 4), 1'b1);

        // asynchronous reset in the middle of a receive
        host_clk_low = 1'b1;
        repeat (3 * P_HALF) step();
        host_dat_low = 1'b1;
        repeat (4) step();
        host_clk_low = 1'b0;
        wait_kclk_en(1'b1, 4 * P_HALF, ok);
        check("rst_mid_rx_clk_low", ok, 1'b1);
        repeat (2) step();
        #2 rst = 1'b1;
        #1;
        check("rst_async_kclk_en", kclk_en, 1'b0);
        check("rst_async_kdat_en", kdat_en, 1'b0);
        check("rst_async_busy", busy_o, 1'b0);
        host_clk_low = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        // request-to-send while a byte is offered: receive wins
        tx_data_i = 8'h33;
        tx_valid_i = 1'b1;
        rd0 = n_ready_cyc; p0 = n_clk_pulse; k0 = n_kdat_cyc; r0 = n_rxv;
        host_send(8'h5A, 1'b1, 1'b1, ok);
        tx_valid_i = 1'b0;
        check("prio_handshake", ok, 1'b1);
        check("prio_no_ready", n_ready_cyc - rd0, 0);
        check("prio_pulses", n_clk_pulse - p0, 11);
        check("prio_ack_cycles", n_kdat_cyc - k0, 2 * P_HALF);
        check("prio_valid_cnt", n_rxv - r0, 1);
        check("prio_data", last_rx_data, 8'h5A);
        check("prio_perr", last_perr, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
